// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline hazard controller sitting after the ID/EX register.
//               Detects load-use, taken-branch and data-memory wait hazards
//               and drives the stall / flush / bubble / hold enables of the
//               PC, IF/ID, ID/EX and EX/MEM registers. Also tracks a memory
//               wait timeout and saturating stall / flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter only needs to reach MAX_WAIT-1; it saturates there.
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic w_freeze;
    logic w_lu;

    // Hazard detection: memory not ready freezes the back end; a load whose
    // destination is a live, non-zero source of the ID instruction stalls.
    always_comb begin
        w_freeze = mem_req & ~dmem_ready;
        w_lu     = ex_memread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end

    // Pipeline enables, priority freeze > branch > load-use > normal;
    // everything forced low while reset is held.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        exmem_hold  = 1'b0;
        if (rst_n) begin
            if (w_freeze) begin
                // Whole pipe stands still; branch/load-use reappear next cycle.
                idex_hold  = 1'b1;
                exmem_hold = 1'b1;
            end else if (ex_branch_taken) begin
                // Squash the wrong-path IF/ID and ID/EX contents.
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (w_lu) begin
                // Hold PC and IF/ID one cycle, insert a bubble behind the load.
                idex_bubble = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    // Next-state: wait FSM, timeout flag and saturating event counters.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (w_freeze) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (w_freeze) begin
                    if (wait_cnt_q == C_WAIT_LAST) begin
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (!pc_write && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush && (flush_cnt_q != C_CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Self-checking bench for hazard_stall_ctrl. A behavioural model
//               derives expected enables from the hazard rules and tracks
//               counters / timeout; literal checks pin key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_memread, ex_branch_taken, mem_req, dmem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // model state
    int m_run  = 0;
    int m_tmo  = 0;
    int m_scnt = 0;
    int m_fcnt = 0;

    hazard_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold}
    function automatic logic [5:0] model_ctrl();
        logic frz, lu;
        if (rst_n !== 1'b1) return 6'b000000;
        frz = mem_req && !dmem_ready;
        lu  = ex_memread && (ex_rt != 0) &&
              ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
        if (frz)             return 6'b000011;
        if (ex_branch_taken) return 6'b111100;
        if (lu)              return 6'b000100;
        return 6'b110000;
    endfunction

    // Model of the registered quantities.
    always @(posedge clk or negedge rst_n) begin
        logic [5:0] e;
        if (!rst_n) begin
            m_run = 0; m_tmo = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            e = model_ctrl();
            if (!e[5] && m_scnt < CNT_MAX) m_scnt = m_scnt + 1;
            if (e[3] && m_fcnt < CNT_MAX)  m_fcnt = m_fcnt + 1;
            if (mem_req && !dmem_ready) begin
                if (m_run >= MAX_WAIT) m_tmo = 1;
                m_run = m_run + 1;
            end else begin
                m_run = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [5:0] e;
        e = model_ctrl();
        check("pc_write",    int'(pc_write),    int'(e[5]));
        check("ifid_write",  int'(ifid_write),  int'(e[4]));
        check("ifid_flush",  int'(ifid_flush),  int'(e[3]));
        check("idex_bubble", int'(idex_bubble), int'(e[2]));
        check("idex_hold",   int'(idex_hold),   int'(e[1]));
        check("exmem_hold",  int'(exmem_hold),  int'(e[0]));
        check("mem_timeout", int'(mem_timeout), m_tmo);
        check("stall_cnt",   int'(stall_cnt),   m_scnt);
        check("flush_cnt",   int'(flush_cnt),   m_fcnt);
    end

    // Apply one cycle of inputs just after the rising edge.
    task automatic cyc(input logic mr, input int ert, input int rs, input int rt,
                       input logic urt, input logic br, input logic mq, input logic rdy);
        @(posedge clk); #1;
        ex_memread = mr; ex_rt = 5'(ert); id_rs = 5'(rs); id_rt = 5'(rt);
        id_uses_rt = urt; ex_branch_taken = br; mem_req = mq; dmem_ready = rdy;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_branch_taken = 0; mem_req = 0; dmem_ready = 0;
        #2;
        check("rst_pc_write", int'(pc_write), 0);
        check("rst_stall_cnt", int'(stall_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        idle(); settle();
        check("lit_idle_pc", int'(pc_write), 1);

        // load-use on rs
        cyc(1, 8, 8, 0, 0, 0, 0, 0); settle();
        check("lit_lu_pc", int'(pc_write), 0);
        check("lit_lu_bubble", int'(idex_bubble), 1);
        idle(); settle();
        check("lit_lu_pc_after", int'(pc_write), 1);
        check("lit_lu_stall_cnt", int'(stall_cnt), 1);

        // $0 and rt-not-used, then rt-used
        cyc(1, 0, 0, 0, 0, 0, 0, 0); settle();
        check("lit_r0_pc", int'(pc_write), 1);
        cyc(1, 9, 0, 9, 0, 0, 0, 0); settle();
        check("lit_nort_pc", int'(pc_write), 1);
        cyc(1, 9, 0, 9, 1, 0, 0, 0); settle();
        check("lit_rt_pc", int'(pc_write), 0);

        // branch with simultaneous load-use
        cyc(1, 8, 8, 0, 0, 1, 0, 0); settle();
        check("lit_br_flush", int'(ifid_flush), 1);
        check("lit_br_pc", int'(pc_write), 1);
        idle(); settle();
        check("lit_br_flush_cnt", int'(flush_cnt), 1);
        check("lit_br_stall_cnt", int'(stall_cnt), 2);

        // memory wait of 3 cycles with a branch pending, released with ready
        cyc(0, 0, 0, 0, 0, 1, 1, 0); settle();
        check("lit_mw_exmem_hold", int'(exmem_hold), 1);
        check("lit_mw_flush", int'(ifid_flush), 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 1); settle();
        check("lit_mw_release_flush", int'(ifid_flush), 1);
        idle(); settle();
        check("lit_mw_stall_cnt", int'(stall_cnt), 5);
        check("lit_mw_flush_cnt", int'(flush_cnt), 2);

        // timeout: 6 frozen cycles
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0); settle();
            if (i == 4) check("lit_tmo_before", int'(mem_timeout), 0);
        end
        check("lit_tmo_set", int'(mem_timeout), 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        idle(); settle();
        check("lit_tmo_sticky", int'(mem_timeout), 1);
        check("lit_tmo_stall_cnt", int'(stall_cnt), 11);

        // saturation of stall counter
        for (int i = 0; i < 6; i++) cyc(1, 3, 3, 0, 0, 0, 0, 0);
        idle(); settle();
        check("lit_sat_stall_cnt", int'(stall_cnt), CNT_MAX);

        // async reset in the middle of a memory wait
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("lit_ar_exmem_hold", int'(exmem_hold), 0);
        check("lit_ar_idex_hold", int'(idex_hold), 0);
        check("lit_ar_stall_cnt", int'(stall_cnt), 0);
        check("lit_ar_tmo", int'(mem_timeout), 0);
        @(negedge clk); #1;
        mem_req = 0; dmem_ready = 0;
        rst_n = 1'b1;
        settle();
        check("lit_ar_pc_after", int'(pc_write), 1);
        check("lit_ar_ifid_after", int'(ifid_write), 1);
        check("lit_ar_hold_after", int'(exmem_hold), 0);
        idle(); idle(); settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control block on the consuming side of the ID/EX pipeline register. It reads the ID/EX control and register-number outputs together with the IF/ID instruction fields.
- Generates the stall, flush, bubble and freeze enables that drive the PC, IF/ID, ID/EX and EX/MEM registers.
- Covers three hazards: load-use, taken branch resolved in EX, and data-memory wait (ready handshake).
- Includes a timeout monitor and performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters (saturating).
- MAX_WAIT, 64, number of consecutive MEM_WAIT cycles after which mem_timeout sets.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_rs  input  5  rs field of the instruction in IF/ID (instr[25:21]).
- id_rt  input  5  rt field of the instruction in IF/ID (instr[20:16]).
- id_uses_rt  input  1  the ID instruction reads rt as a source (R-type, store, branch).
- ex_memread  input  1  MemRead bit of the ID/EX M control group.
- ex_rt  input  5  rt register number held in ID/EX.
- ex_branch_taken  input  1  branch resolved taken in EX this cycle.
- mem_req  input  1  the MEM-stage instruction accesses data memory.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC load enable.
- ifid_write  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID loads a NOP.
- idex_bubble  output  1  ID/EX loads zeroed WB/M/EX control groups.
- idex_hold  output  1  ID/EX keeps its contents.
- exmem_hold  output  1  EX/MEM keeps its contents.
- mem_timeout  output  1  sticky error flag.
- stall_cnt  output  CNT_W  cycles lost to stalls.
- flush_cnt  output  CNT_W  taken-branch flush events.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
  - All six enable/flush/hold outputs are forced to 0 while reset is asserted.
- FSM states: RUN and MEM_WAIT. Outputs are combinational from state and inputs; state and counters are registered.
- Derived signals:
  - freeze = mem_req & ~dmem_ready.
  - lu = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- Output priority: freeze > branch > load-use > normal.
  - Freeze: pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, ifid_flush=0, idex_bubble=0. A branch or load-use condition present during freeze is ignored; it is re-evaluated each cycle because the frozen stages keep presenting it.
  - Branch (ex_branch_taken, no freeze): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, holds=0. This wins over a simultaneous load-use because the ID instruction is squashed.
  - Load-use (lu, no freeze, no branch): pc_write=0, ifid_write=0, idex_bubble=1, holds=0. Exactly one stall cycle per load; the next cycle the bubble sits in ID/EX, so lu clears by itself.
  - Normal: pc_write=1, ifid_write=1, all others 0.
- FSM transitions:
  - RUN -> MEM_WAIT when freeze=1.
  - MEM_WAIT stays while freeze=1; MEM_WAIT -> RUN when freeze=0 (dmem_ready=1 or mem_req dropped). The release cycle is a normal or branch/lu cycle per the priority rules.
- wait_cnt:
  - Increments each MEM_WAIT cycle with freeze=1; clears on return to RUN.
  - When wait_cnt reaches MAX_WAIT-1 with freeze still 1, mem_timeout sets on that edge.
  - mem_timeout is cleared only by reset. Pipeline behaviour is unaffected (freeze continues).
- Counters:
  - stall_cnt increments on every cycle with pc_write=0 outside reset (freeze or load-use).
  - flush_cnt increments on every branch-flush cycle.
  - Both saturate at all-ones (no wrap).
- Register $0 is never a load-use hazard (ex_rt=0 gives lu=0).
- Reset asserted mid-MEM_WAIT returns to RUN immediately; no hold persists after release.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle ex_memread=0 -> normal; stall_cnt=1.
- $0 and no-rt-use cases: ex_rt=0, id_rs=0 -> no stall. ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
- Branch with simultaneous load-use: ex_branch_taken=1 while lu=1 -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 cycles with exmem_hold=1, idex_hold=1, pc_write=0; state returns to RUN on the ready cycle; stall_cnt=3. A branch asserted during the wait takes effect on the release cycle.
- Timeout: MAX_WAIT=4, dmem_ready held 0 for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after ready returns; only rst_n clears it.
- Async reset: rst_n pulled low mid-MEM_WAIT (no clock edge) -> all control outputs 0 and counters 0 immediately; after release with idle inputs -> pc_write=1, ifid_write=1.
